// File: rtl/bytex64_munch_pkg.sv
// Shared VGA 640x480@60 timing constants and output-packing helpers for the
// munching-squares tile.
package munch_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = 10'd800;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = 10'd525;

  localparam logic [9:0] DRAW_W    = 10'd512;

  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;

  // Syncs idle high, colour dark.
  localparam logic [7:0] UO_IDLE = 8'h88;

  // rgb is {B1,B0,G1,G0,R1,R0}; TinyVGA puts the low colour bits in the upper nibble.
  function automatic logic [7:0] pack_uo(input logic hsync, input logic vsync,
                                         input logic [5:0] rgb);
    return {hsync, rgb[4], rgb[2], rgb[0], vsync, rgb[5], rgb[3], rgb[1]};
  endfunction

  function automatic logic in_sync(input logic [9:0] pos, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/bytex64_munch_vga_timing.sv
// Free-running horizontal/vertical raster counters with active-low syncs,
// a visible-area flag and a one-cycle end-of-frame strobe.
module vga_timing
  import munch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       frame_end
);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       h_last_s;
  logic       v_last_s;

  // Next-state for the raster counters: vpos only moves on an hpos wrap.
  always_comb begin
    h_last_s = (hpos_q == H_LAST);
    v_last_s = (vpos_q == V_LAST);
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    if (h_last_s) begin
      hpos_d = 10'd0;
      if (v_last_s) begin
        vpos_d = 10'd0;
      end else begin
        vpos_d = vpos_q + 10'd1;
      end
    end else begin
      hpos_d = hpos_q + 10'd1;
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q <= 10'd0;
      vpos_q <= 10'd0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  // Decoded timing flags, all derived from the current counter state.
  always_comb begin
    hpos      = hpos_q;
    vpos      = vpos_q;
    hsync     = ~in_sync(hpos_q, H_SYNC_START, H_SYNC_END);
    vsync     = ~in_sync(vpos_q, V_SYNC_START, V_SYNC_END);
    visible   = (hpos_q < H_VISIBLE) && (vpos_q < V_VISIBLE);
    frame_end = h_last_s && v_last_s;
  end

endmodule

// File: rtl/bytex64_munch.sv
// Tiny Tapeout tile: 640x480 VGA munching-squares pattern (pixel lit when
// xs^ys < t), output on the TinyVGA PMOD pinout.
module bytex64_munch
  import munch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [9:0] hpos_s;
  logic [9:0] vpos_s;
  logic       hsync_s;
  logic       vsync_s;
  logic       visible_s;
  logic       frame_end_s;

  logic [7:0] t_q, t_d;
  logic [7:0] uo_q, uo_d;
  logic [7:0] xs_s, ys_s, p_s;
  logic       on_s;
  logic       in_draw_s;
  logic [5:0] rgb_s;
  logic       unused_s;

  vga_timing u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .hpos      (hpos_s),
    .vpos      (vpos_s),
    .hsync     (hsync_s),
    .vsync     (vsync_s),
    .visible   (visible_s),
    .frame_end (frame_end_s)
  );

  // Pixel decision; visible already bounds vpos to the active lines.
  always_comb begin
    xs_s      = hpos_s[8:1];
    ys_s      = vpos_s[8:1];
    p_s       = xs_s ^ ys_s;
    on_s      = (p_s < t_q) ^ ui_in[7];
    in_draw_s = visible_s && (hpos_s < DRAW_W);
    rgb_s     = 6'd0;
    if (in_draw_s && on_s) begin
      rgb_s = ui_in[5:0];
    end else begin
      rgb_s = 6'd0;
    end
    uo_d = pack_uo(hsync_s, vsync_s, rgb_s);
  end

  // Frame counter advances once per frame unless paused.
  always_comb begin
    t_d = t_q;
    if (frame_end_s && !ui_in[6]) begin
      t_d = t_q + 8'd1;
    end else begin
      t_d = t_q;
    end
  end

  // Output register keeps syncs and colour on the same pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q  <= 8'd0;
      uo_q <= UO_IDLE;
    end else begin
      t_q  <= t_d;
      uo_q <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'd0;
  assign uio_oe  = 8'd0;

  assign unused_s = &{ena, uio_in, vpos_s[9], vpos_s[0], 1'b0};

endmodule

// File: tb/tb_bytex64_munch.sv
// Self-checking bench for bytex64_munch: raster-level reference model compared
// every cycle, plus hand-computed pixel/sync expectations.
module tb_bytex64_munch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  bytex64_munch dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h want=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a raster position (h,v) and frame count t, output from the VGA rules.
  function automatic logic [7:0] model_uo(int h, int v, int t, logic [7:0] ui);
    logic [7:0] o;
    int p;
    bit lit;
    o    = 8'h00;
    o[7] = (h >= 656 && h < 752) ? 1'b0 : 1'b1;
    o[3] = (v >= 490 && v < 492) ? 1'b0 : 1'b1;
    p    = ((h / 2) % 256) ^ ((v / 2) % 256);
    lit  = (p < t) ^ ui[7];
    if (h < 512 && v < 480 && lit) begin
      o[4] = ui[0]; o[0] = ui[1];
      o[5] = ui[2]; o[1] = ui[3];
      o[6] = ui[4]; o[2] = ui[5];
    end
    return o;
  endfunction

  int m_h = 0, m_v = 0, m_t = 0;
  logic [7:0] m_exp = 8'h88;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_t = 0; m_exp = 8'h88;
    end else begin
      m_exp = model_uo(m_h, m_v, m_t, ui_in);
      if (m_h == 799 && m_v == 524 && !ui_in[6]) m_t = (m_t + 1) % 256;
      m_h = m_h + 1;
      if (m_h == 800) begin
        m_h = 0;
        m_v = (m_v + 1) % 525;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("model", uo_out, m_exp);
  end

  // Stimulus for edge k (k=1 is the first edge after reset release).
  function automatic logic [7:0] stim_ui(int k);
    int line, hp;
    logic [7:0] colour_tab [6];
    logic [7:0] line_tab [4];
    colour_tab = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0};
    line_tab   = '{8'h95, 8'hEA, 8'h3F, 8'hC0};
    line = (k - 1) / 800;
    hp   = (k - 1) % 800;
    if (line == 0) return 8'h3F;
    if (line == 1) return 8'hFF;
    if (line == 2) return (hp < 6) ? colour_tab[hp] : 8'hBF;
    if (line == 3) return 8'h7F;
    if (line == 4) return 8'h40;
    return line_tab[line % 4];
  endfunction

  localparam int PH1_EDGES = 64 * 800;

  initial begin
    int fall1, rise1, fall2;
    logic prev_h;
    logic [7:0] ui_tab [6];
    ui_tab = '{8'h98, 8'h89, 8'hA8, 8'h8A, 8'hC8, 8'h8C};
    fall1 = 0; rise1 = 0; fall2 = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'hA5;
    ui_in  = stim_ui(1);
    repeat (5) @(negedge clk);
    chk_en = 1'b1;
    check("reset_uo", uo_out, 8'h88);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    rst_n  = 1'b1;
    prev_h = 1'b1;

    for (int k = 1; k <= PH1_EDGES; k++) begin
      @(negedge clk);
      if (prev_h && !uo_out[7]) begin
        if (fall1 == 0) fall1 = k;
        else if (fall2 == 0) fall2 = k;
      end
      if (!prev_h && uo_out[7] && rise1 == 0) rise1 = k;
      prev_h = uo_out[7];
      if (k == 1)    check("t0_pixel00", uo_out, 8'h88);
      if (k == 801)  check("inv_h0_v1", uo_out, 8'hFF);
      if (k == 1312) check("inv_h511", uo_out, 8'hFF);
      if (k == 1313) check("inv_h512", uo_out, 8'h88);
      if (k == 1401) check("inv_h600", uo_out, 8'h88);
      if (k == 1457) check("inv_hsync", uo_out, 8'h08);
      if (k >= 1601 && k <= 1606) check("colour_map", uo_out, ui_tab[k - 1601]);
      if (k == 2401) check("pause_noinv", uo_out, 8'h88);
      ui_in = stim_ui(k + 1);
    end
    check("hsync_first_fall", 8'(fall1 == 657), 8'd1);
    check("hsync_width", 8'(rise1 - fall1 == 96), 8'd1);
    check("hsync_period", 8'(fall2 - fall1 == 800), 8'd1);

    // Reset in the middle of a line: counters and output return to idle.
    rst_n = 1'b0;
    ui_in = 8'hFF;
    @(negedge clk);
    check("midreset_uo", uo_out, 8'h88);
    rst_n  = 1'b1;
    fall1  = 0;
    prev_h = 1'b1;
    for (int k = 1; k <= 900; k++) begin
      @(negedge clk);
      if (prev_h && !uo_out[7] && fall1 == 0) fall1 = k;
      prev_h = uo_out[7];
      if (k == 1) check("post_reset_pixel00", uo_out, 8'hFF);
    end
    check("post_reset_hsync", 8'(fall1 == 657), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bytex64_munch.md
Name: bytex64_munch

Overview:
- Tiny Tapeout user block that generates a 640x480@60 Hz VGA "munching squares" animation on the TinyVGA PMOD pinout of uo_out.
- A pixel is lit when the XOR of its scaled x/y coordinates is below a per-frame counter, producing the classic growing/collapsing XOR pattern.
- Top-level of the tile; the bidirectional IOs are unused.

Parameters:
- none (timing fixed by package constants)

Ports:
- clk  in  1  pixel clock, 25.175 MHz nominal (25 MHz acceptable)
- rst_n  in  1  synchronous active-low reset
- ena  in  1  tile-selected; ignored, design runs regardless
- ui_in  in  8  [1:0]=R, [3:2]=G, [5:4]=B foreground colour (msb first); [6]=pause; [7]=invert
- uio_in  in  8  unused
- uo_out  out  8  [7]=hsync, [6]=B0, [5]=G0, [4]=R0, [3]=vsync, [2]=B1, [1]=G1, [0]=R1
- uio_out  out  8  constant 0
- uio_oe  out  8  constant 0 (all inputs)

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n), sampled on the rising edge of clk.
- Reset values:
  - hpos=0, vpos=0, frame counter t=0.
  - uo_out=8'h88: syncs inactive-high, all colour bits 0.
- hpos counts 0..799 and wraps to 0; vpos increments on each hpos wrap and counts 0..524, then wraps to 0.
- Horizontal timing: visible 0-639, front porch 640-655, hsync 656-751 (active low, 96 clk), back porch 752-799.
- Vertical timing: visible 0-479, front porch 480-489, vsync lines 490-491 (active low), back porch 492-524.
- Pattern:
  - xs=hpos[8:1], ys=vpos[8:1], both 8 bit; p=xs^ys.
  - on = (p < t) XOR ui_in[7].
- Drawing window: hpos<512 and vpos<480.
  - Inside the window, colour = ui_in[5:0] when on, else 0.
  - Outside the window, and during all blanking, colour = 0.
- Frame counter t (8 bit):
  - Increments by 1 on the cycle where hpos=799 and vpos=524, unless ui_in[6]=1; then it holds.
  - Wraps 255->0.
  - t=0 means nothing is lit, since p<0 is never true.
- Latency: all uo_out bits are registered together. uo_out at cycle n+1 reflects the hpos/vpos/t of cycle n, so syncs and colour stay aligned.
- ui_in is sampled combinationally into the output register; there is no synchronizer requirement.
- Reset asserted mid-frame: on the next edge, counters return to 0 and uo_out=8'h88.

Decomposition:
- Package munch_pkg holds the constants:
  - H_VISIBLE=640, H_FRONT=16, H_SYNC=96, H_BACK=48, H_TOTAL=800.
  - V_VISIBLE=480, V_FRONT=10, V_SYNC=2, V_BACK=33, V_TOTAL=525.
  - DRAW_W=512.
- One sub-module, vga_timing:
  - Holds the hpos/vpos counters.
  - Outputs hsync, vsync, visible, and frame_end (hpos=799 and vpos=524).
- The top module holds t, the pattern compare and the output register.

Test Plan:
- Reset: rst_n=0 for 5 clk -> uo_out=0x88, uio_out=0x00, uio_oe=0x00.
- Horizontal timing: release reset and count clocks -> uo_out[7] first goes low at clk edge 657 after release; it stays low 96 clk and repeats every 800 clk.
- Vertical timing: run one frame -> uo_out[3] is low for exactly 1600 clk starting at line 490, with period 420000 clk.
- First frame (t=0), ui_in=0x3F -> every colour bit stays 0 all frame, i.e. uo_out is only ever 0x88/0x08/0x80/0x00.
- Second frame (t=1), ui_in=0x3F -> the pixel at hpos=0,vpos=0 gives uo_out=0xFF. A pixel with p≠0 (hpos=2,vpos=0) gives 0x88. hpos=600 (outside the drawing window) gives 0x88.
- Pause/invert:
  - ui_in=0x40 held for 3 frames -> t stays 0.
  - With ui_in=0xFF at t=0 -> all pixels with hpos<512 in visible lines are lit; uo_out=0xFF there.
